// File: rtl/ddr5_cmd_sequencer.sv
// Single-channel, in-order DDR5 command sequencer (open-page policy).
// One request in flight; tracks the open row and tRAS window of all 32 banks.
module ddr5_cmd_sequencer #(
   parameter int T_RCD   = 39,
   parameter int T_RP    = 39,
   parameter int T_RAS   = 76,
   parameter int T_CL    = 40,
   parameter int T_CWD   = 38,
   parameter int T_BURST = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_row,
   input  logic [2:0]  req_bank_group,
   input  logic [1:0]  req_bank,
   input  logic [9:0]  req_col,
   output logic        cmd_valid,
   output logic [3:0]  cmd,
   output logic [2:0]  cmd_bg,
   output logic [1:0]  cmd_bank,
   output logic [15:0] cmd_row,
   output logic [9:0]  cmd_col,
   output logic        done,
   output logic [3:0]  dbg_state
);

   // Handshake: a request transfers on the rising edge where req_valid && req_ready;
   // req_ready is high only while idle, and req_* fields need only be stable that cycle.

   localparam logic [3:0] CMD_NULL = 4'd0, CMD_ACT0 = 4'd1, CMD_ACT1 = 4'd2, CMD_RD0 = 4'd3,
                          CMD_RD1  = 4'd4, CMD_WR0  = 4'd5, CMD_WR1  = 4'd6, CMD_PRE = 4'd7;

   // Each load is the spacing minus the fixed cycles spent in the surrounding states.
   localparam logic [7:0] RAS_LOAD = 8'(T_RAS - 1);
   localparam logic [7:0] RP_LOAD  = 8'(T_RP - 2);
   localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 3);
   localparam logic [7:0] RD_LOAD  = 8'(T_CL + T_BURST - 2);
   localparam logic [7:0] WR_LOAD  = 8'(T_CWD + T_BURST - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_WAIT_RP, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_DATA
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  wait_cnt, wait_cnt_nx;
   logic        lat_write;
   logic [15:0] lat_row;
   logic [2:0]  lat_bg;
   logic [1:0]  lat_bank;
   logic [9:0]  lat_col;
   logic [31:0] open_valid;
   logic [15:0] open_row [32];
   logic [7:0]  tras_cnt [32];

   logic        accept;
   logic [4:0]  req_idx, lat_idx;
   logic        cmd_valid_nx, done_nx;
   logic [3:0]  cmd_nx;
   logic [2:0]  bg_nx;
   logic [1:0]  bank_nx;
   logic [15:0] row_nx;
   logic [9:0]  col_nx;

   assign req_idx   = {req_bank_group, req_bank};
   assign lat_idx   = {lat_bg, lat_bank};
   assign dbg_state = state;

   // The command for the next cycle is decided here and registered, so each state
   // names the command that is on the bus while the FSM sits in it.
   always_comb begin
      state_nx     = state;
      wait_cnt_nx  = wait_cnt;
      accept       = 1'b0;
      cmd_valid_nx = 1'b0;
      cmd_nx       = CMD_NULL;
      bg_nx        = 3'd0;
      bank_nx      = 2'd0;
      row_nx       = 16'd0;
      col_nx       = 10'd0;
      done_nx      = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               bg_nx   = req_bank_group;
               bank_nx = req_bank;
               if (open_valid[req_idx] && open_row[req_idx] == req_row) begin
                  state_nx     = S_CAS0;
                  cmd_valid_nx = 1'b1;
                  cmd_nx       = req_write ? CMD_WR0 : CMD_RD0;
                  col_nx       = req_col;
               end else if (!open_valid[req_idx]) begin
                  state_nx     = S_ACT0;
                  cmd_valid_nx = 1'b1;
                  cmd_nx       = CMD_ACT0;
                  row_nx       = req_row;
               end else begin
                  state_nx     = S_PRE;
                  cmd_valid_nx = (tras_cnt[req_idx] <= 8'd1);
                  cmd_nx       = cmd_valid_nx ? CMD_PRE : CMD_NULL;
                  if (!cmd_valid_nx) begin
                     bg_nx   = 3'd0;
                     bank_nx = 2'd0;
                  end
               end
            end
         end
         S_PRE: begin
            if (cmd_valid) begin
               state_nx    = S_WAIT_RP;
               wait_cnt_nx = RP_LOAD;
            end else if (tras_cnt[lat_idx] <= 8'd1) begin
               // tRAS expires by the next cycle, so PRE may be on the bus then
               cmd_valid_nx = 1'b1;
               cmd_nx       = CMD_PRE;
               bg_nx        = lat_bg;
               bank_nx      = lat_bank;
            end
         end
         S_WAIT_RP: begin
            if (wait_cnt == 8'd0) begin
               state_nx     = S_ACT0;
               cmd_valid_nx = 1'b1;
               cmd_nx       = CMD_ACT0;
               bg_nx        = lat_bg;
               bank_nx      = lat_bank;
               row_nx       = lat_row;
            end else begin
               wait_cnt_nx = wait_cnt - 8'd1;
            end
         end
         S_ACT0: begin
            state_nx     = S_ACT1;
            cmd_valid_nx = 1'b1;
            cmd_nx       = CMD_ACT1;
            bg_nx        = lat_bg;
            bank_nx      = lat_bank;
            row_nx       = lat_row;
         end
         S_ACT1: begin
            state_nx    = S_WAIT_RCD;
            wait_cnt_nx = RCD_LOAD;
         end
         S_WAIT_RCD: begin
            if (wait_cnt == 8'd0) begin
               state_nx     = S_CAS0;
               cmd_valid_nx = 1'b1;
               cmd_nx       = lat_write ? CMD_WR0 : CMD_RD0;
               bg_nx        = lat_bg;
               bank_nx      = lat_bank;
               col_nx       = lat_col;
            end else begin
               wait_cnt_nx = wait_cnt - 8'd1;
            end
         end
         S_CAS0: begin
            state_nx     = S_CAS1;
            cmd_valid_nx = 1'b1;
            cmd_nx       = lat_write ? CMD_WR1 : CMD_RD1;
            bg_nx        = lat_bg;
            bank_nx      = lat_bank;
            col_nx       = lat_col;
         end
         S_CAS1: begin
            state_nx    = S_WAIT_DATA;
            wait_cnt_nx = lat_write ? WR_LOAD : RD_LOAD;
         end
         S_WAIT_DATA: begin
            done_nx = (wait_cnt == 8'd1);
            if (wait_cnt == 8'd0) state_nx = S_IDLE;
            else                  wait_cnt_nx = wait_cnt - 8'd1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         wait_cnt  <= 8'd0;
         req_ready <= 1'b1;
         cmd_valid <= 1'b0;
         cmd       <= CMD_NULL;
         cmd_bg    <= 3'd0;
         cmd_bank  <= 2'd0;
         cmd_row   <= 16'd0;
         cmd_col   <= 10'd0;
         done      <= 1'b0;
         lat_write <= 1'b0;
         lat_row   <= 16'd0;
         lat_bg    <= 3'd0;
         lat_bank  <= 2'd0;
         lat_col   <= 10'd0;
      end else begin
         state     <= state_nx;
         wait_cnt  <= wait_cnt_nx;
         req_ready <= (state_nx == S_IDLE);
         cmd_valid <= cmd_valid_nx;
         cmd       <= cmd_nx;
         cmd_bg    <= bg_nx;
         cmd_bank  <= bank_nx;
         cmd_row   <= row_nx;
         cmd_col   <= col_nx;
         done      <= done_nx;
         if (accept) begin
            lat_write <= req_write;
            lat_row   <= req_row;
            lat_bg    <= req_bank_group;
            lat_bank  <= req_bank;
            lat_col   <= req_col;
         end
      end
   end

   // Bank table: ACT0 opens the row and arms tRAS; an issued PRE closes the bank.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         open_valid <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            open_row[i] <= 16'd0;
            tras_cnt[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (state == S_ACT0 && 5'(i) == lat_idx) begin
               open_valid[i] <= 1'b1;
               open_row[i]   <= lat_row;
               tras_cnt[i]   <= RAS_LOAD;
            end else begin
               if (state == S_PRE && cmd_valid && 5'(i) == lat_idx) open_valid[i] <= 1'b0;
               if (tras_cnt[i] != 8'd0) tras_cnt[i] <= tras_cnt[i] - 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer: default-timing instance plus a T_RAS=120 instance,
// with per-cycle checks of the full command bus against hand-computed command schedules.
module tb_ddr5_cmd_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid, req_valid2, req_write;
   logic [15:0] req_row;
   logic [2:0]  req_bank_group;
   logic [1:0]  req_bank;
   logic [9:0]  req_col;

   logic        ready_a, cmd_valid_a, done_a, ready_b, cmd_valid_b, done_b;
   logic [3:0]  cmd_a, cmd_b, dbg_a, dbg_b;
   logic [2:0]  bg_a, bg_b;
   logic [1:0]  bank_a, bank_b;
   logic [15:0] row_a, row_b;
   logic [9:0]  col_a, col_b;

   always #5 clock = ~clock;

   ddr5_cmd_sequencer dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_a),
      .req_write(req_write), .req_row(req_row), .req_bank_group(req_bank_group),
      .req_bank(req_bank), .req_col(req_col), .cmd_valid(cmd_valid_a), .cmd(cmd_a),
      .cmd_bg(bg_a), .cmd_bank(bank_a), .cmd_row(row_a), .cmd_col(col_a), .done(done_a),
      .dbg_state(dbg_a)
   );

   ddr5_cmd_sequencer #(.T_RAS(120)) dut_ras (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(ready_b),
      .req_write(req_write), .req_row(req_row), .req_bank_group(req_bank_group),
      .req_bank(req_bank), .req_col(req_col), .cmd_valid(cmd_valid_b), .cmd(cmd_b),
      .cmd_bg(bg_b), .cmd_bank(bank_b), .cmd_row(row_b), .cmd_col(col_b), .done(done_b),
      .dbg_state(dbg_b)
   );

   // Packed bus view: {pad, ready, cmd_valid, cmd, bg, bank, row, col, done}
   logic [39:0] raw_a, raw_b;
   assign raw_a = {2'b00, ready_a, cmd_valid_a, cmd_a, bg_a, bank_a, row_a, col_a, done_a};
   assign raw_b = {2'b00, ready_b, cmd_valid_b, cmd_b, bg_b, bank_b, row_b, col_b, done_b};

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int base  = 0;
   bit sel   = 1'b0;

   typedef struct {
      int         rel;
      logic [3:0] c;
   } ev_t;
   ev_t exp_q[$];

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d rel=%0d observed=%h expected=%h", tag, cyc, cyc - base, obs, exp);
      end
   endtask

   // Row is only meaningful with ACT*, column only with RD*/WR*.
   function automatic logic [39:0] mask_bus(input logic [39:0] v);
      logic [39:0] m;
      m = v;
      if (v[36]) begin
         if (v[35:32] == 4'd1 || v[35:32] == 4'd2) m[10:1] = 10'd0;
         else if (v[35:32] >= 4'd3 && v[35:32] <= 4'd6) m[26:11] = 16'd0;
         else if (v[35:32] == 4'd7) begin
            m[10:1]  = 10'd0;
            m[26:11] = 16'd0;
         end
      end
      return m;
   endfunction

   function automatic logic [39:0] observe();
      return mask_bus(sel ? raw_b : raw_a);
   endfunction

   task automatic add_ev(input int rel, input logic [3:0] c);
      ev_t e;
      e.rel = rel;
      e.c   = c;
      exp_q.push_back(e);
   endtask

   // Called at a negedge in the cycle where the request should be accepted.
   task automatic send(input bit s, input bit w, input logic [15:0] row, input logic [2:0] bg,
                       input logic [1:0] bk, input logic [9:0] col);
      sel = s;
      chk("ready_idle", {39'd0, s ? ready_b : ready_a}, 40'd1);
      req_write      = w;
      req_row        = row;
      req_bank_group = bg;
      req_bank       = bk;
      req_col        = col;
      if (s) req_valid2 = 1'b1;
      else   req_valid  = 1'b1;
      base = cyc;
      @(negedge clock);
      req_valid  = 1'b0;
      req_valid2 = 1'b0;
   endtask

   // Check every cycle from base+1 to base+done_rel against the expected schedule.
   task automatic walk(input string tag, input int done_rel, input logic [15:0] row,
                       input logic [2:0] bg, input logic [1:0] bk, input logic [9:0] col);
      logic [3:0]  c;
      logic [39:0] e;
      for (int r = 1; r <= done_rel; r++) begin
         while (cyc < base + r) @(negedge clock);
         c = 4'd0;
         foreach (exp_q[k]) if (exp_q[k].rel == r) c = exp_q[k].c;
         e = 40'd0;
         e[36] = (c != 4'd0);
         e[35:32] = c;
         if (c != 4'd0) begin
            e[31:29] = bg;
            e[28:27] = bk;
         end
         if (c == 4'd1 || c == 4'd2) e[26:11] = row;
         if (c >= 4'd3 && c <= 4'd6) e[10:1] = col;
         e[0] = (r == done_rel);
         chk(tag, observe(), e);
      end
      exp_q.delete();
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      req_valid = 1'b0;
      req_valid2 = 1'b0;
      req_write = 1'b0;
      req_row = 16'd0;
      req_bank_group = 3'd0;
      req_bank = 2'd0;
      req_col = 10'd0;
      repeat (3) @(negedge clock);
      chk("reset_bus_a", raw_a, 40'h20_0000_0000);
      chk("reset_bus_b", raw_b, 40'h20_0000_0000);
      chk("reset_state", {36'd0, dbg_a}, 40'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_reset_bus", raw_a, 40'h20_0000_0000);

      // Empty bank read: ACT0 c1, ACT1 c2, RD0 c40, RD1 c41, done c88
      send(1'b0, 1'b0, 16'd5, 3'd0, 2'd0, 10'd0);
      add_ev(1, 4'd1); add_ev(2, 4'd2); add_ev(40, 4'd3); add_ev(41, 4'd4);
      walk("empty_read", 88, 16'd5, 3'd0, 2'd0, 10'd0);

      // Page hit: RD0 c90, RD1 c91, done c138
      send(1'b0, 1'b0, 16'd5, 3'd0, 2'd0, 10'd8);
      add_ev(1, 4'd3); add_ev(2, 4'd4);
      walk("hit_read", 49, 16'd5, 3'd0, 2'd0, 10'd8);

      // Conflict write with tRAS met: PRE c140, ACT0 c179, ACT1 c180, WR0 c218, WR1 c219, done c264
      send(1'b0, 1'b1, 16'd6, 3'd0, 2'd0, 10'h055);
      add_ev(1, 4'd7); add_ev(40, 4'd1); add_ev(41, 4'd2); add_ev(79, 4'd5); add_ev(80, 4'd6);
      walk("conflict_write", 125, 16'd6, 3'd0, 2'd0, 10'h055);

      // Highest bank, extreme row/column: empty-bank activate
      send(1'b0, 1'b0, 16'hFFFF, 3'd7, 2'd3, 10'h3FF);
      add_ev(1, 4'd1); add_ev(2, 4'd2); add_ev(40, 4'd3); add_ev(41, 4'd4);
      walk("bg7_b3_read", 88, 16'hFFFF, 3'd7, 2'd3, 10'h3FF);

      // BG0/B0 still has row 6 open: must be a hit
      send(1'b0, 1'b0, 16'd6, 3'd0, 2'd0, 10'h12);
      add_ev(1, 4'd3); add_ev(2, 4'd4);
      walk("bg0_still_open", 49, 16'd6, 3'd0, 2'd0, 10'h12);

      // T_RAS=120 instance: open row 5, then conflict at c89 -> PRE held until c121, ACT0 c160
      send(1'b1, 1'b0, 16'd5, 3'd0, 2'd0, 10'd0);
      add_ev(1, 4'd1); add_ev(2, 4'd2); add_ev(40, 4'd3); add_ev(41, 4'd4);
      walk("ras_first", 88, 16'd5, 3'd0, 2'd0, 10'd0);
      send(1'b1, 1'b0, 16'd6, 3'd0, 2'd0, 10'd4);
      chk("ras_hold_state", {36'd0, dbg_b}, 40'd1);
      add_ev(32, 4'd7); add_ev(71, 4'd1); add_ev(72, 4'd2); add_ev(110, 4'd3); add_ev(111, 4'd4);
      walk("ras_conflict", 158, 16'd6, 3'd0, 2'd0, 10'd4);

      // Reset during WAIT_RCD abandons the request and clears the bank table
      send(1'b0, 1'b0, 16'h1234, 3'd2, 2'd1, 10'h0AA);
      while (cyc < base + 10) @(negedge clock);
      chk("abort_in_wait_rcd", {36'd0, dbg_a}, 40'd5);
      reset_n = 1'b0;
      #1;
      chk("async_reset_bus", raw_a, 40'h20_0000_0000);
      chk("async_reset_state", {36'd0, dbg_a}, 40'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("after_abort_bus", raw_a, 40'h20_0000_0000);
      send(1'b0, 1'b0, 16'h1234, 3'd2, 2'd1, 10'h0AA);
      add_ev(1, 4'd1); add_ev(2, 4'd2); add_ev(40, 4'd3); add_ev(41, 4'd4);
      walk("rerequest_empty", 88, 16'h1234, 3'd2, 2'd1, 10'h0AA);
      chk("final_ready", {39'd0, ready_a}, 40'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
